// File: rtl/sos_coef_if.sv
// Sample handshake and host configuration bus shared between the SOS
// coefficient controller and its environment.
interface sos_coef_if #(
  parameter int CW = 24
);
  logic                 s_valid_in;
  logic                 s_ready;
  logic                 sos_valid_in;
  logic                 casc_valid_out;
  logic                 cfg_we;
  logic [5:0]           cfg_addr;
  logic signed [CW-1:0] cfg_wdata;
  logic                 cfg_commit;
  logic                 cfg_busy;
  logic                 cfg_err;
  logic [7:0]           swap_cnt;

  modport master (
    output s_valid_in, casc_valid_out, cfg_we, cfg_addr, cfg_wdata, cfg_commit,
    input  s_ready, sos_valid_in, cfg_busy, cfg_err, swap_cnt
  );

  modport slave (
    input  s_valid_in, casc_valid_out, cfg_we, cfg_addr, cfg_wdata, cfg_commit,
    output s_ready, sos_valid_in, cfg_busy, cfg_err, swap_cnt
  );
endinterface

// File: rtl/sos_coef_ctrl.sv
// Shadow/active coefficient banks and sample gating for a biquad cascade.
// Define SOS_FLUSH_ON_SWAP_EN to clear section history for 2 cycles after each swap.
module sos_coef_ctrl #(
  parameter int NUM_SEC = 4,
  parameter int CW      = 24,
  parameter int CNT_W   = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sos_coef_if.slave             bus,
  output logic [NUM_SEC*CW-1:0] b0_o,
  output logic [NUM_SEC*CW-1:0] b1_o,
  output logic [NUM_SEC*CW-1:0] b2_o,
  output logic [NUM_SEC*CW-1:0] a1_o,
  output logic [NUM_SEC*CW-1:0] a2_o,
  output logic                  sec_clr_n
);

  localparam int                   NUM_COEF = 5;
  localparam logic signed [CW-1:0] COEF_ONE = {2'b01, {(CW-2){1'b0}}};
  localparam logic [CNT_W-1:0]     CNT_MAX  = '1;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    SWAP  = 2'd2
`ifdef SOS_FLUSH_ON_SWAP_EN
    ,
    CLEAR = 2'd3
`endif
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [CNT_W-1:0]     inflight;
  logic                 busy;
  logic                 err;
  logic [7:0]           swap_cnt;

  logic [2:0]           wr_sec;
  logic [2:0]           wr_coef;
  logic                 addr_legal;
  logic                 wr_ok;
  logic                 wr_bad;
  logic                 commit_bad;
  logic                 ready;
  logic                 inc;
  logic                 dec;
  logic                 underflow;

  logic signed [CW-1:0] shadow [NUM_SEC][NUM_COEF];
  logic signed [CW-1:0] active [NUM_SEC][NUM_COEF];

  // Address decode and error sources
  assign wr_sec     = bus.cfg_addr[5:3];
  assign wr_coef    = bus.cfg_addr[2:0];
  assign addr_legal = (wr_coef < 3'd5) && (int'(wr_sec) < NUM_SEC);
  assign wr_ok      = bus.cfg_we && addr_legal;
  assign wr_bad     = bus.cfg_we && !addr_legal;
  assign commit_bad = bus.cfg_commit && (state != RUN);

  // Sample gating: the cascade only sees samples while running and not full
  assign ready            = (state == RUN) && (inflight != CNT_MAX);
  assign bus.s_ready      = ready;
  assign bus.sos_valid_in = bus.s_valid_in & ready;

  assign inc       = bus.s_valid_in & ready;
  assign dec       = bus.casc_valid_out;
  assign underflow = dec && !inc && (inflight == '0);

  assign bus.cfg_busy = busy;
  assign bus.cfg_err  = err;
  assign bus.swap_cnt = swap_cnt;

`ifdef SOS_FLUSH_ON_SWAP_EN
  logic clr_cnt;
  logic clr_n;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:   if (bus.cfg_commit) state_nxt = DRAIN;
      DRAIN: if (inflight == '0) state_nxt = SWAP;
`ifdef SOS_FLUSH_ON_SWAP_EN
      SWAP:  state_nxt = CLEAR;
      CLEAR: if (clr_cnt) state_nxt = RUN;
`else
      SWAP:  state_nxt = RUN;
`endif
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      inflight <= '0;
      busy     <= 1'b0;
      err      <= 1'b0;
      swap_cnt <= 8'd0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != RUN);
      err   <= wr_bad | commit_bad | underflow;
      if (inc && !dec)
        inflight <= inflight + CNT_W'(1);
      else if (dec && !inc && (inflight != '0))
        inflight <= inflight - CNT_W'(1);
      if (state == SWAP)
        swap_cnt <= swap_cnt + 8'd1;
    end
  end

`ifdef SOS_FLUSH_ON_SWAP_EN
  // clr_cnt marks the second CLEAR cycle so the clear pulse is exactly 2 cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_cnt <= 1'b0;
      clr_n   <= 1'b1;
    end else begin
      clr_cnt <= (state == CLEAR) && !clr_cnt;
      clr_n   <= (state_nxt != CLEAR);
    end
  end
  assign sec_clr_n = clr_n;
`else
  assign sec_clr_n = 1'b1;
`endif

  // Shadow bank: host writes land here in any state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NUM_SEC; s++)
        for (int c = 0; c < NUM_COEF; c++)
          shadow[s][c] <= (c == 0) ? COEF_ONE : '0;
    end else begin
      for (int s = 0; s < NUM_SEC; s++)
        for (int c = 0; c < NUM_COEF; c++)
          if (wr_ok && (wr_sec == 3'(s)) && (wr_coef == 3'(c)))
            shadow[s][c] <= bus.cfg_wdata;
    end
  end

  // Active bank: whole-bank copy in SWAP; a same-cycle host write is not seen
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NUM_SEC; s++)
        for (int c = 0; c < NUM_COEF; c++)
          active[s][c] <= (c == 0) ? COEF_ONE : '0;
    end else if (state == SWAP) begin
      for (int s = 0; s < NUM_SEC; s++)
        for (int c = 0; c < NUM_COEF; c++)
          active[s][c] <= shadow[s][c];
    end
  end

  for (genvar k = 0; k < NUM_SEC; k++) begin : g_out
    assign b0_o[k*CW +: CW] = active[k][0];
    assign b1_o[k*CW +: CW] = active[k][1];
    assign b2_o[k*CW +: CW] = active[k][2];
    assign a1_o[k*CW +: CW] = active[k][3];
    assign a2_o[k*CW +: CW] = active[k][4];
  end

endmodule

// File: tb/tb_sos_coef_ctrl.sv
// Directed bench for sos_coef_ctrl: reset, idle commit, drain, illegal
// accesses, in-flight boundaries and reset during drain.
module tb_sos_coef_ctrl;
  localparam int NUM_SEC = 4;
  localparam int CW      = 24;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NUM_SEC*CW-1:0] b0_o, b1_o, b2_o, a1_o, a2_o;
  logic                  sec_clr_n;
  int                    n_cmp = 0;
  int                    n_bad = 0;

  sos_coef_if #(.CW(CW)) bus ();

  sos_coef_ctrl #(.NUM_SEC(NUM_SEC), .CW(CW), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .b0_o(b0_o), .b1_o(b1_o), .b2_o(b2_o), .a1_o(a1_o), .a2_o(a2_o),
    .sec_clr_n(sec_clr_n)
  );

  always #5 clk = ~clk;

  function automatic logic [CW-1:0] sl(input logic [NUM_SEC*CW-1:0] v, input int k);
    return v[k*CW +: CW];
  endfunction

  task automatic chkb(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %06h expected %06h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string p);
    for (int k = 0; k < NUM_SEC; k++) begin
      chkw({p, "_b0"}, sl(b0_o, k), 24'h400000);
      chkw({p, "_b1"}, sl(b1_o, k), 24'h000000);
      chkw({p, "_b2"}, sl(b2_o, k), 24'h000000);
      chkw({p, "_a1"}, sl(a1_o, k), 24'h000000);
      chkw({p, "_a2"}, sl(a2_o, k), 24'h000000);
    end
    chkb({p, "_ready"}, bus.s_ready, 1'b1);
    chkb({p, "_busy"}, bus.cfg_busy, 1'b0);
    chkb({p, "_err"}, bus.cfg_err, 1'b0);
    chk8({p, "_swap_cnt"}, bus.swap_cnt, 8'd0);
    chkb({p, "_clr_n"}, sec_clr_n, 1'b1);
  endtask

  task automatic write(input logic [2:0] sec, input logic [2:0] coef, input logic [CW-1:0] d);
    bus.cfg_we    = 1'b1;
    bus.cfg_addr  = {sec, coef};
    bus.cfg_wdata = d;
    tick();
    bus.cfg_we = 1'b0;
    #1;
  endtask

  // Commit with nothing in flight: SWAP at T+2, RUN at T+3 (T+5 with flush)
  task automatic commit_idle(input string p, input logic [7:0] exp_cnt);
    bus.cfg_commit = 1'b1;
    #1;
    chkb({p, "_ready_T"}, bus.s_ready, 1'b1);
    tick();
    bus.cfg_commit = 1'b0;
    #1;
    chkb({p, "_busy_T1"}, bus.cfg_busy, 1'b1);
    chkb({p, "_ready_T1"}, bus.s_ready, 1'b0);
    tick();
    chkb({p, "_busy_T2"}, bus.cfg_busy, 1'b1);
    chk8({p, "_cnt_T2"}, bus.swap_cnt, exp_cnt - 8'd1);
    tick();
    chk8({p, "_cnt_T3"}, bus.swap_cnt, exp_cnt);
`ifdef SOS_FLUSH_ON_SWAP_EN
    chkb({p, "_busy_T3"}, bus.cfg_busy, 1'b1);
    chkb({p, "_clr_T3"}, sec_clr_n, 1'b0);
    tick();
    chkb({p, "_clr_T4"}, sec_clr_n, 1'b0);
    tick();
    chkb({p, "_clr_T5"}, sec_clr_n, 1'b1);
`endif
    chkb({p, "_busy_run"}, bus.cfg_busy, 1'b0);
    chkb({p, "_ready_run"}, bus.s_ready, 1'b1);
  endtask

  initial begin
    rst_n              = 1'b0;
    bus.s_valid_in     = 1'b0;
    bus.casc_valid_out = 1'b0;
    bus.cfg_we         = 1'b0;
    bus.cfg_addr       = 6'd0;
    bus.cfg_wdata      = '0;
    bus.cfg_commit     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset("rst_hold");
    rst_n = 1'b1;
    tick();
    chk_reset("rst");

    // Idle commit of sec2 a1
    write(3'd2, 3'd3, 24'hE00000);
    chkb("wr_a1_err", bus.cfg_err, 1'b0);
    chkw("wr_a1_active_old", sl(a1_o, 2), 24'h000000);
    bus.cfg_commit = 1'b1;
    tick();
    bus.cfg_commit = 1'b0;
    #1;
    chkb("idle_busy_T1", bus.cfg_busy, 1'b1);
    chkb("idle_ready_T1", bus.s_ready, 1'b0);
    tick();
    chkb("idle_busy_T2", bus.cfg_busy, 1'b1);
    chkw("idle_a1_T2", sl(a1_o, 2), 24'h000000);
    tick();
    chkw("idle_a1_T3", sl(a1_o, 2), 24'hE00000);
    chk8("idle_cnt_T3", bus.swap_cnt, 8'd1);
`ifdef SOS_FLUSH_ON_SWAP_EN
    chkb("idle_busy_T3", bus.cfg_busy, 1'b1);
    chkb("idle_clr_T3", sec_clr_n, 1'b0);
    tick();
    chkb("idle_busy_T4", bus.cfg_busy, 1'b1);
    chkb("idle_clr_T4", sec_clr_n, 1'b0);
    tick();
    chkb("idle_clr_T5", sec_clr_n, 1'b1);
`endif
    chkb("idle_busy_run", bus.cfg_busy, 1'b0);
    chkb("idle_ready_run", bus.s_ready, 1'b1);

    // Drain: 2 samples before commit, a third accepted with the commit
    bus.s_valid_in = 1'b1;
    tick();
    tick();
    bus.cfg_commit = 1'b1;
    #1;
    chkb("drain_acc_T", bus.sos_valid_in, 1'b1);
    tick();
    for (int c = 1; c <= 11; c++) begin
      bus.casc_valid_out = (c == 4) || (c == 6) || (c == 9);
      bus.cfg_commit     = (c == 5);
      bus.cfg_we         = (c == 2) || (c == 11);
      bus.cfg_addr       = {3'd0, 3'd1};
      bus.cfg_wdata      = (c == 2) ? 24'h123456 : 24'h0AAAAA;
      #1;
      chkb($sformatf("drain_ready_c%0d", c), bus.s_ready, 1'b0);
      chkb($sformatf("drain_sosv_c%0d", c), bus.sos_valid_in, 1'b0);
      chkb($sformatf("drain_busy_c%0d", c), bus.cfg_busy, 1'b1);
      chkb($sformatf("drain_err_c%0d", c), bus.cfg_err, c == 6);
      if (c >= 9) chk8($sformatf("drain_cnt_c%0d", c), bus.swap_cnt, 8'd1);
      if (c == 11) chkw("drain_b1_swapcyc", sl(b1_o, 0), 24'h000000);
      tick();
    end
    bus.casc_valid_out = 1'b0;
    bus.cfg_commit     = 1'b0;
    bus.cfg_we         = 1'b0;
    bus.s_valid_in     = 1'b0;
    #1;
    chkw("drain_b1_new", sl(b1_o, 0), 24'h123456);
    chkw("drain_a1_kept", sl(a1_o, 2), 24'hE00000);
    chk8("drain_cnt_done", bus.swap_cnt, 8'd2);
`ifdef SOS_FLUSH_ON_SWAP_EN
    chkb("drain_clr_0", sec_clr_n, 1'b0);
    chkb("drain_busy_clr", bus.cfg_busy, 1'b1);
    tick();
    chkb("drain_clr_1", sec_clr_n, 1'b0);
    tick();
    chkb("drain_clr_2", sec_clr_n, 1'b1);
`endif
    chkb("drain_busy_run", bus.cfg_busy, 1'b0);
    chkb("drain_ready_run", bus.s_ready, 1'b1);
    tick();
    chkb("no_second_swap_busy", bus.cfg_busy, 1'b0);
    chk8("no_second_swap_cnt", bus.swap_cnt, 8'd2);

    // Illegal writes, then a legal one, then commit to expose the shadow
    write(3'd0, 3'd6, 24'h111111);
    chkb("bad_coef_err", bus.cfg_err, 1'b1);
    tick();
    chkb("bad_coef_err_end", bus.cfg_err, 1'b0);
    write(3'(NUM_SEC), 3'd0, 24'h000000);
    chkb("bad_sec_err", bus.cfg_err, 1'b1);
    tick();
    chkb("bad_sec_err_end", bus.cfg_err, 1'b0);
    write(3'd3, 3'd4, 24'h7FFFFF);
    chkb("good_a2_err", bus.cfg_err, 1'b0);
    commit_idle("ill", 8'd3);
    chkw("ill_b1_swapwrite", sl(b1_o, 0), 24'h0AAAAA);
    chkw("ill_a2_sec3", sl(a2_o, 3), 24'h7FFFFF);
    chkw("ill_b2_sec0", sl(b2_o, 0), 24'h000000);
    for (int k = 0; k < NUM_SEC; k++)
      chkw($sformatf("ill_b0_sec%0d", k), sl(b0_o, k), 24'h400000);

    // Fill to 63 in flight
    bus.s_valid_in = 1'b1;
    #1;
    for (int i = 0; i < 63; i++) begin
      if (i == 62) chkb("fill_62_ready", bus.s_ready, 1'b1);
      tick();
    end
    chkb("full_ready", bus.s_ready, 1'b0);
    chkb("full_sosv", bus.sos_valid_in, 1'b0);
    bus.casc_valid_out = 1'b1;
    #1;
    chkb("full_inout_sosv", bus.sos_valid_in, 1'b0);
    tick();
    chkb("after_full_out_ready", bus.s_ready, 1'b1);
    chkb("at62_inout_sosv", bus.sos_valid_in, 1'b1);
    tick();
    bus.casc_valid_out = 1'b0;
    bus.s_valid_in     = 1'b0;
    #1;
    chkb("at62_inout_ready", bus.s_ready, 1'b1);
    chkb("at62_inout_err", bus.cfg_err, 1'b0);
    bus.s_valid_in = 1'b1;
    tick();
    bus.s_valid_in = 1'b0;
    #1;
    chkb("refill_63_ready", bus.s_ready, 1'b0);
    bus.casc_valid_out = 1'b1;
    repeat (63) tick();
    bus.casc_valid_out = 1'b0;
    #1;
    chkb("emptied_err", bus.cfg_err, 1'b0);
    chkb("emptied_ready", bus.s_ready, 1'b1);
    bus.casc_valid_out = 1'b1;
    tick();
    bus.casc_valid_out = 1'b0;
    #1;
    chkb("underflow_err", bus.cfg_err, 1'b1);
    tick();
    chkb("underflow_err_end", bus.cfg_err, 1'b0);
    commit_idle("zero", 8'd4);

    // Reset while draining one sample with a pending shadow write
    bus.s_valid_in = 1'b1;
    tick();
    bus.s_valid_in = 1'b0;
    write(3'd1, 3'd2, 24'h222222);
    bus.cfg_commit = 1'b1;
    tick();
    bus.cfg_commit = 1'b0;
    #1;
    chkb("rdrain_busy_T1", bus.cfg_busy, 1'b1);
    tick();
    chkb("rdrain_busy_T2", bus.cfg_busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk_reset("rdrain");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    commit_idle("post_rst", 8'd1);
    chkw("post_rst_b2_sec1", sl(b2_o, 1), 24'h000000);
    chkw("post_rst_a1_sec2", sl(a1_o, 2), 24'h000000);
    chkw("post_rst_b0_sec0", sl(b0_o, 0), 24'h400000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
